// File: rtl/prio_rr_arbiter.sv
// prio_rr_arbiter
// N-channel priority arbiter with round-robin tie-breaking, anti-starvation
// aging and a one-entry registered output stage feeding a single destination.
//
// Handshake: a source transfer happens in the cycle where valid_i[k] and
// ready_i[k] are both 1. The output transfer happens in the cycle where valid_o
// and ready_o are both 1. Once valid_o rises, data_o and src_o stay stable
// until that output transfer completes. A new source is accepted only when the
// output register is empty or is being drained in the same cycle.
module prio_rr_arbiter #(
    parameter int NUM_CH    = 8,
    parameter int DATA_W    = 32,
    parameter int PRIO_W    = 3,
    parameter int AGE_LIMIT = 15,
    localparam int SRC_W    = $clog2(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_CH-1:0]          valid_i,
    input  logic [NUM_CH*DATA_W-1:0]   data_i,
    input  logic [NUM_CH*PRIO_W-1:0]   priority_i,
    output logic [NUM_CH-1:0]          ready_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       valid_o,
    output logic [SRC_W-1:0]           src_o,
    input  logic                       ready_o
);

    // Age counters need at least one bit even when aging is disabled.
    localparam int AGE_W = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;
    // Arbitration key: urgency bit above the source priority.
    localparam int KEY_W = PRIO_W + 1;

    // Output stage and fairness state
    logic                valid_q;
    logic [DATA_W-1:0]   data_q;
    logic [SRC_W-1:0]    src_q;
    logic [SRC_W-1:0]    last_q;
    logic [AGE_W-1:0]    age_q [NUM_CH];
    logic [AGE_W-1:0]    age_d [NUM_CH];

    // Arbitration datapath
    logic                load;
    logic                any_valid;
    logic                grant;
    logic [NUM_CH-1:0]   urgent;
    logic [KEY_W-1:0]    key [NUM_CH];
    logic [KEY_W-1:0]    max_key;
    logic [SRC_W-1:0]    win_idx;
    logic [DATA_W-1:0]   win_data;

    // The output register can accept a new word when empty or being drained.
    assign load      = !valid_q || ready_o;
    assign any_valid = |valid_i;
    // Nothing is granted while reset is held, even though load is true then.
    assign grant     = load && any_valid && reset_n;

    // Build each channel's key; a channel that lost AGE_LIMIT times jumps above
    // every non-urgent channel regardless of priority.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            urgent[k] = (AGE_LIMIT != 0) && (age_q[k] == AGE_W'(AGE_LIMIT));
            key[k]    = {urgent[k], priority_i[k*PRIO_W +: PRIO_W]};
        end
    end

    // Highest key among the requesting channels.
    always_comb begin
        max_key = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (valid_i[k] && (key[k] > max_key)) begin
                max_key = key[k];
            end
        end
    end

    // Round-robin scan starting after the last granted channel; the first
    // requester holding the maximum key wins. The index wraps modulo NUM_CH,
    // which need not be a power of two.
    always_comb begin
        logic             found;
        logic [SRC_W:0]   sum;
        logic [SRC_W-1:0] idx;
        found   = 1'b0;
        win_idx = '0;
        sum     = '0;
        idx     = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            sum = {1'b0, last_q} + (SRC_W+1)'(i);
            if (sum >= (SRC_W+1)'(NUM_CH)) begin
                sum = sum - (SRC_W+1)'(NUM_CH);
            end
            idx = sum[SRC_W-1:0];
            if (!found && valid_i[idx] && (key[idx] == max_key)) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    // One-hot accept towards the winning source and the matching data mux.
    always_comb begin
        ready_i  = '0;
        win_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (win_idx == SRC_W'(k)) begin
                ready_i[k] = grant;
                win_data   = data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next age per channel: idle or granted channels restart, losers count up
    // to the limit, everything holds when no grant happens this cycle.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            age_d[k] = age_q[k];
            if (!valid_i[k] || ready_i[k]) begin
                age_d[k] = '0;
            end else if (grant && (age_q[k] != AGE_W'(AGE_LIMIT))) begin
                age_d[k] = age_q[k] + 1'b1;
            end
        end
    end

    // Output register and round-robin pointer; reset points the pointer at the
    // last channel so channel 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
            last_q  <= SRC_W'(NUM_CH - 1);
        end else if (grant) begin
            valid_q <= 1'b1;
            data_q  <= win_data;
            src_q   <= win_idx;
            last_q  <= win_idx;
        end else if (load) begin
            valid_q <= 1'b0;
        end
    end

    // Age counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                age_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                age_q[k] <= age_d[k];
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign src_o   = src_q;

endmodule

// File: doc/prio_rr_arbiter.md
# prio_rr_arbiter

Parametrised N-channel priority arbiter with round-robin tie-breaking, anti-starvation aging and a registered output stage. Each source channel presents valid, data and priority. The block grants at most one channel per cycle into a one-entry output register that drives the single destination channel. It is the configurable successor to the fixed 8-channel priority arbiter and sits between the source-channel and destination-channel interfaces in the same test harness.

## Interface
- NUM_CH, 8: number of source channels (2..32)
- DATA_W, 32: data width per channel
- PRIO_W, 3: priority width; a larger value means higher priority
- AGE_LIMIT, 15: number of lost arbitrations before a waiting channel becomes urgent; 0 disables aging
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous reset, active-low
- valid_i  input  NUM_CH  per-channel request valid
- data_i  input  NUM_CH*DATA_W  per-channel data; channel k occupies bits [k*DATA_W +: DATA_W]
- priority_i  input  NUM_CH*PRIO_W  per-channel priority; channel k occupies bits [k*PRIO_W +: PRIO_W]
- ready_i  output  NUM_CH  per-channel accept, one-hot or zero
- data_o  output  DATA_W  registered output data
- valid_o  output  1  registered output valid
- src_o  output  clog2(NUM_CH)  index of the channel that supplied data_o
- ready_o  input  1  destination ready

## Operation
- load = !valid_o || ready_o. This is the only condition under which arbitration grants.
- Effective key of channel k = {urgent[k], priority_i[k]}. urgent[k] = (AGE_LIMIT != 0) && (age[k] == AGE_LIMIT).
- Winner: the valid channel with the maximum key. Ties are resolved round-robin: search starts at last_grant+1, wraps modulo NUM_CH, and the first channel holding the maximum key wins.
- ready_i[g] = 1 only when load is 1, some valid_i is set, and g is the winner. All other ready_i bits are 0. ready_i is combinational from valid_i, priority_i, valid_o and ready_o.
- On grant: data_o <= data_i[g], src_o <= g, valid_o <= 1, last_grant <= g.
- On load with no valid channel: valid_o <= 0; data_o and src_o hold their values.
- While valid_o && !ready_o: data_o, src_o and valid_o hold; last_grant holds; ages hold.
- Age counters, one per channel, width clog2(AGE_LIMIT+1):
  - cleared when valid_i[k] = 0, or when k is granted;
  - incremented, saturating at AGE_LIMIT, when valid_i[k] = 1 and another channel is granted this cycle;
  - otherwise held.
- Sources must hold valid_i, data_i and priority_i stable until accepted. The block does not check this.

## Timing
- Reset values (asynchronous on reset_n low): valid_o=0, data_o=0, src_o=0, all ages=0, last_grant=NUM_CH-1, so channel 0 wins the first tie. ready_i=0 for as long as reset_n is low.
- Latency: grant in cycle T puts the data on data_o/valid_o in cycle T+1.
- Throughput: one transfer per cycle while ready_o=1.
- Simultaneous drain and grant in the same cycle (valid_o && ready_o && any valid_i): the output is replaced without a bubble.
- Destination back-pressure: with ready_o=0 and valid_o=1, all ready_i bits are 0 in the same cycle.
- Reset asserted mid-transfer: the pending output is dropped, and arbitration fairness state returns to its reset values.
- Release of reset is synchronised externally; no grant occurs in the cycle reset_n is low.

## Test plan
- Reset, then valid_i=8'hFF, all priorities 3, ready_o=1 -> src_o sequence 0,1,2,…,7,0 on consecutive cycles starting one cycle after the first grant.
- ch2 priority 5 and ch6 priority 1, both valid, ready_o=1, AGE_LIMIT=15 -> ch2 granted 15 times in a row, then ch6 becomes urgent and is granted on the 16th grant, then ch2 resumes.
- Same stimulus with AGE_LIMIT=0 -> ch6 is never granted while ch2 stays valid.
- valid_o=1, ready_o held 0 for 4 cycles with ch0/ch1 valid -> ready_i=0 throughout, data_o/src_o stable, ages unchanged; ready_o=1 -> drain and new grant in the same cycle, no bubble.
- Only ch3 valid with data 32'hDEAD_BEEF, ready_o=1 -> ready_i=8'h08 in cycle T, data_o=32'hDEAD_BEEF, src_o=3, valid_o=1 in T+1; valid_i=0 afterwards -> valid_o=0 in T+2.
- reset_n pulsed low while valid_o=1 -> valid_o=0 immediately (asynchronous); the next tie is won by ch0.
